// File: rtl/execute_stage_pkg.sv
// Shared definitions for the MIPS execute stage.
// Holds the ALU control encodings, the R-type funct codes and I-type opcodes,
// the bit positions of the WB/MEM/EX control fields and the internal ALU op set.
package execute_stage_pkg;

  // Bit positions inside the pipelined control fields.
  localparam int unsigned WbRegWrite = 1;
  localparam int unsigned WbMemToReg = 0;
  localparam int unsigned MemBranch  = 2;
  localparam int unsigned MemRead    = 1;
  localparam int unsigned MemWrite   = 0;
  localparam int unsigned ExeRegDst  = 3;
  localparam int unsigned ExeAluOpHi = 2;
  localparam int unsigned ExeAluOpLo = 1;
  localparam int unsigned ExeAluSrc  = 0;
  localparam int unsigned OpcValid   = 6;

  // ALUOp field driven by the main decoder.
  typedef enum logic [1:0] {
    AluCtrlMem    = 2'b00,
    AluCtrlBranch = 2'b01,
    AluCtrlRType  = 2'b10,
    AluCtrlImm    = 2'b11
  } alu_ctrl_e;

  // R-type funct codes.
  localparam logic [5:0] FunctSll  = 6'h00;
  localparam logic [5:0] FunctSrl  = 6'h02;
  localparam logic [5:0] FunctSra  = 6'h03;
  localparam logic [5:0] FunctSllv = 6'h04;
  localparam logic [5:0] FunctSrlv = 6'h06;
  localparam logic [5:0] FunctSrav = 6'h07;
  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctAddu = 6'h21;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctSubu = 6'h23;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctXor  = 6'h26;
  localparam logic [5:0] FunctNor  = 6'h27;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctSltu = 6'h2B;

  // I-type opcodes.
  localparam logic [5:0] OpcBeq   = 6'h04;
  localparam logic [5:0] OpcBne   = 6'h05;
  localparam logic [5:0] OpcAddi  = 6'h08;
  localparam logic [5:0] OpcAddiu = 6'h09;
  localparam logic [5:0] OpcSlti  = 6'h0A;
  localparam logic [5:0] OpcSltiu = 6'h0B;
  localparam logic [5:0] OpcAndi  = 6'h0C;
  localparam logic [5:0] OpcOri   = 6'h0D;
  localparam logic [5:0] OpcXori  = 6'h0E;
  localparam logic [5:0] OpcLui   = 6'h0F;

  // Operation set understood by the ALU sub-module.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11,
    AluZero = 4'd12
  } alu_op_e;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU for the execute stage.
// Ports: a, b     - operands (shifts operate on b)
//        shamt    - shift amount
//        op       - operation select (alu_op_e)
//        result   - 32-bit result, arithmetic wraps modulo 2^32
//        zero     - result == 0
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic    [31:0] a,
  input  logic    [31:0] b,
  input  logic    [4:0]  shamt,
  input  alu_op_e        op,
  output logic    [31:0] result,
  output logic           zero
);

  always_comb begin
    result = '0;
    unique case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNor:  result = ~(a | b);
      AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
      AluSltu: result = {31'b0, a < b};
      AluSll:  result = b << shamt;
      AluSrl:  result = b >> shamt;
      AluSra:  result = 32'($signed(b) >>> shamt);
      AluLui:  result = {b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline.
// Selects (optionally forwarded) operands, decodes ALUOp/funct/opcode for the
// ALU, resolves BEQ/BNE combinationally and registers the EX/MEM latch.
// Optional feature macro: FORWARDING_EN (EX/MEM and MEM/WB operand forwarding).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   stop_debug           - freezes the EX/MEM latch and suppresses branches
//   inWB/inMEM/inEXE     - control fields from ID/EX
//   inInstructionAddress - PC+4, inRegA/inRegB register operands
//   inInstruction_ls     - sign-extended immediate (funct/shamt in low bits)
//   in_rs/in_rt/inRT_rd  - register indices, inInmmediateOpcode {valid, opcode}
//   MEM_* / WB_*         - forwarding sources
//   outPCSel/outPCJump   - branch decision and target (combinational)
//   outWB/outMEM/outALUResult/outALUZero/outRegB/outRegF_wreg - EX/MEM latch
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stop_debug,
  input  logic [1:0]  inWB,
  input  logic [2:0]  inMEM,
  input  logic [3:0]  inEXE,
  input  logic [31:0] inInstructionAddress,
  input  logic [31:0] inRegA,
  input  logic [31:0] inRegB,
  input  logic [31:0] inInstruction_ls,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  inRT_rd,
  input  logic [6:0]  inInmmediateOpcode,
  input  logic [31:0] MEM_AluResult,
  input  logic [4:0]  MEM_rd,
  input  logic        MEM_regF_wr,
  input  logic [31:0] WB_regF_wd,
  input  logic [4:0]  WB_rd,
  input  logic        WB_regF_wr,
  output logic [1:0]  outWB,
  output logic [2:0]  outMEM,
  output logic        outPCSel,
  output logic [31:0] outPCJump,
  output logic [31:0] outALUResult,
  output logic        outALUZero,
  output logic [31:0] outRegB,
  output logic [4:0]  outRegF_wreg
);

  logic [31:0] fwd_a, fwd_b, op_b;
  logic [31:0] alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
  alu_op_e     alu_op;
  alu_ctrl_e   alu_ctrl;
  logic [5:0]  funct, opcode;
  logic        opc_valid, branch_taken;

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
`ifdef FORWARDING_EN
  // EX/MEM is younger than MEM/WB, so it wins when both match; r0 never forwards.
  always_comb begin
    fwd_a = inRegA;
    if (MEM_regF_wr && (MEM_rd != 5'd0) && (MEM_rd == in_rs)) begin
      fwd_a = MEM_AluResult;
    end else if (WB_regF_wr && (WB_rd != 5'd0) && (WB_rd == in_rs)) begin
      fwd_a = WB_regF_wd;
    end
  end

  always_comb begin
    fwd_b = inRegB;
    if (MEM_regF_wr && (MEM_rd != 5'd0) && (MEM_rd == in_rt)) begin
      fwd_b = MEM_AluResult;
    end else if (WB_regF_wr && (WB_rd != 5'd0) && (WB_rd == in_rt)) begin
      fwd_b = WB_regF_wd;
    end
  end
`else
  // Software guarantees no hazards; forwarding sources are unused.
  assign fwd_a = inRegA;
  assign fwd_b = inRegB;

  logic unused_fwd;
  assign unused_fwd = ^{in_rs, MEM_AluResult, MEM_rd, MEM_regF_wr,
                        WB_regF_wd, WB_rd, WB_regF_wr};
`endif

  assign op_b      = inEXE[ExeAluSrc] ? inInstruction_ls : fwd_b;
  assign alu_ctrl  = alu_ctrl_e'(inEXE[ExeAluOpHi:ExeAluOpLo]);
  assign funct     = inInstruction_ls[5:0];
  assign opcode    = inInmmediateOpcode[5:0];
  assign opc_valid = inInmmediateOpcode[OpcValid];

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_op    = AluZero;
    alu_b     = op_b;
    alu_shamt = inInstruction_ls[10:6];
    case (alu_ctrl)
      AluCtrlMem:    alu_op = AluAdd;
      AluCtrlBranch: alu_op = AluSub;
      AluCtrlRType: begin
        case (funct)
          FunctAdd, FunctAddu: alu_op = AluAdd;
          FunctSub, FunctSubu: alu_op = AluSub;
          FunctAnd:            alu_op = AluAnd;
          FunctOr:             alu_op = AluOr;
          FunctXor:            alu_op = AluXor;
          FunctNor:            alu_op = AluNor;
          FunctSlt:            alu_op = AluSlt;
          FunctSltu:           alu_op = AluSltu;
          // Shifts always act on the rt value, never the immediate.
          FunctSll: begin alu_op = AluSll; alu_b = fwd_b; end
          FunctSrl: begin alu_op = AluSrl; alu_b = fwd_b; end
          FunctSra: begin alu_op = AluSra; alu_b = fwd_b; end
          FunctSllv: begin alu_op = AluSll; alu_b = fwd_b; alu_shamt = fwd_a[4:0]; end
          FunctSrlv: begin alu_op = AluSrl; alu_b = fwd_b; alu_shamt = fwd_a[4:0]; end
          FunctSrav: begin alu_op = AluSra; alu_b = fwd_b; alu_shamt = fwd_a[4:0]; end
          default:             alu_op = AluZero;
        endcase
      end
      AluCtrlImm: begin
        alu_b = inInstruction_ls;
        if (opc_valid) begin
          case (opcode)
            OpcAddi, OpcAddiu: alu_op = AluAdd;
            OpcSlti:           alu_op = AluSlt;
            OpcSltiu:          alu_op = AluSltu;
            // Logical immediates are zero-extended, not sign-extended.
            OpcAndi: begin alu_op = AluAnd; alu_b = {16'h0000, inInstruction_ls[15:0]}; end
            OpcOri:  begin alu_op = AluOr;  alu_b = {16'h0000, inInstruction_ls[15:0]}; end
            OpcXori: begin alu_op = AluXor; alu_b = {16'h0000, inInstruction_ls[15:0]}; end
            OpcLui:            alu_op = AluLui;
            default:           alu_op = AluZero;
          endcase
        end
      end
      default: alu_op = AluZero;
    endcase
  end

  execute_stage_alu u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .shamt  (alu_shamt),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // ---------------------------------------------------------------------------
  // Branch resolution (feeds fetch and flushes ID in the same cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_taken = 1'b0;
    if (opcode == OpcBeq) branch_taken = (fwd_a == fwd_b);
    if (opcode == OpcBne) branch_taken = (fwd_a != fwd_b);
  end

  assign outPCSel  = inMEM[MemBranch] & branch_taken & ~stop_debug & ~rst;
  assign outPCJump = inInstructionAddress + (inInstruction_ls << 2);

  // ---------------------------------------------------------------------------
  // EX/MEM latch
  // ---------------------------------------------------------------------------
  logic [1:0]  wb_q;
  logic [2:0]  mem_q;
  logic [31:0] result_q, regb_q;
  logic        zero_q;
  logic [4:0]  wreg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      mem_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      regb_q   <= '0;
      wreg_q   <= '0;
    end else if (!stop_debug) begin
      wb_q     <= inWB;
      mem_q    <= inMEM;
      result_q <= alu_result;
      zero_q   <= alu_zero;
      regb_q   <= fwd_b;
      wreg_q   <= inEXE[ExeRegDst] ? inRT_rd : in_rt;
    end
  end

  assign outWB        = wb_q;
  assign outMEM       = mem_q;
  assign outALUResult = result_q;
  assign outALUZero   = zero_q;
  assign outRegB      = regb_q;
  assign outRegF_wreg = wreg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver computes the expected outputs
// from a behavioural model and queues them; a monitor pops one entry per clock.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stop_debug;
  logic [1:0]  inWB;
  logic [2:0]  inMEM;
  logic [3:0]  inEXE;
  logic [31:0] inInstructionAddress, inRegA, inRegB, inInstruction_ls;
  logic [4:0]  in_rs, in_rt, inRT_rd;
  logic [6:0]  inInmmediateOpcode;
  logic [31:0] MEM_AluResult, WB_regF_wd;
  logic [4:0]  MEM_rd, WB_rd;
  logic        MEM_regF_wr, WB_regF_wr;
  logic [1:0]  outWB;
  logic [2:0]  outMEM;
  logic        outPCSel, outALUZero;
  logic [31:0] outPCJump, outALUResult, outRegB;
  logic [4:0]  outRegF_wreg;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .stop_debug           (stop_debug),
    .inWB                 (inWB),
    .inMEM                (inMEM),
    .inEXE                (inEXE),
    .inInstructionAddress (inInstructionAddress),
    .inRegA               (inRegA),
    .inRegB               (inRegB),
    .inInstruction_ls     (inInstruction_ls),
    .in_rs                (in_rs),
    .in_rt                (in_rt),
    .inRT_rd              (inRT_rd),
    .inInmmediateOpcode   (inInmmediateOpcode),
    .MEM_AluResult        (MEM_AluResult),
    .MEM_rd               (MEM_rd),
    .MEM_regF_wr          (MEM_regF_wr),
    .WB_regF_wd           (WB_regF_wd),
    .WB_rd                (WB_rd),
    .WB_regF_wr           (WB_regF_wr),
    .outWB                (outWB),
    .outMEM               (outMEM),
    .outPCSel             (outPCSel),
    .outPCJump            (outPCJump),
    .outALUResult         (outALUResult),
    .outALUZero           (outALUZero),
    .outRegB              (outRegB),
    .outRegF_wreg         (outRegF_wreg)
  );

  typedef struct packed {
    logic        pcsel;
    logic [31:0] pcjump;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] res;
    logic        zero;
    logic [31:0] regb;
    logic [4:0]  wreg;
  } exp_t;

  exp_t exp_q[$];
  exp_t state;  // model of the EX/MEM latch contents
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Operand value as the instruction should see it.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef FORWARDING_EN
    if (MEM_regF_wr && MEM_rd != 0 && MEM_rd == idx) return MEM_AluResult;
    if (WB_regF_wr && WB_rd != 0 && WB_rd == idx) return WB_regF_wd;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] fb);
    logic [31:0] imm, b, zimm;
    int          sh, vsh;
    imm  = inInstruction_ls;
    zimm = {16'h0, imm[15:0]};
    b    = inEXE[0] ? imm : fb;
    sh   = int'(imm[10:6]);
    vsh  = int'(a[4:0]);
    case (inEXE[2:1])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        case (imm[5:0])
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return fb << sh;
          6'h02: return fb >> sh;
          6'h03: return 32'($signed(fb) >>> sh);
          6'h04: return fb << vsh;
          6'h06: return fb >> vsh;
          6'h07: return 32'($signed(fb) >>> vsh);
          default: return 32'd0;
        endcase
      end
      default: begin
        if (!inInmmediateOpcode[6]) return 32'd0;
        case (inInmmediateOpcode[5:0])
          6'h08, 6'h09: return a + imm;
          6'h0A: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
          6'h0B: return (a < imm) ? 32'd1 : 32'd0;
          6'h0C: return a & zimm;
          6'h0D: return a | zimm;
          6'h0E: return a ^ zimm;
          6'h0F: return {imm[15:0], 16'h0};
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // Called just after a falling edge with inputs applied: queue the expectation
  // for the coming rising edge, then advance to the next falling edge.
  task automatic apply();
    logic [31:0] a, fb, r;
    logic        taken;
    exp_t        e;
    a  = operand(in_rs, inRegA);
    fb = operand(in_rt, inRegB);
    r  = ref_result(a, fb);
    taken = (inInmmediateOpcode[5:0] == 6'h04 && a == fb) ||
            (inInmmediateOpcode[5:0] == 6'h05 && a != fb);
    if (rst) begin
      state = '0;
    end else if (!stop_debug) begin
      state.wb   = inWB;
      state.mem  = inMEM;
      state.res  = r;
      state.zero = (r == 32'd0);
      state.regb = fb;
      state.wreg = inEXE[3] ? inRT_rd : in_rt;
    end
    e        = state;
    e.pcsel  = inMEM[2] && taken && !stop_debug && !rst;
    e.pcjump = inInstructionAddress + (inInstruction_ls << 2);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every rising edge, compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pcsel",  {31'b0, outPCSel},     {31'b0, e.pcsel});
        check("pcjump", outPCJump,             e.pcjump);
        check("wb",     {30'b0, outWB},        {30'b0, e.wb});
        check("mem",    {29'b0, outMEM},       {29'b0, e.mem});
        check("result", outALUResult,          e.res);
        check("zero",   {31'b0, outALUZero},   {31'b0, e.zero});
        check("regb",   outRegB,               e.regb);
        check("wreg",   {27'b0, outRegF_wreg}, {27'b0, e.wreg});
      end
    end
  end

  task automatic clear_inputs();
    rst = 1'b0; stop_debug = 1'b0;
    inWB = '0; inMEM = '0; inEXE = '0;
    inInstructionAddress = '0; inRegA = '0; inRegB = '0; inInstruction_ls = '0;
    in_rs = '0; in_rt = '0; inRT_rd = '0; inInmmediateOpcode = '0;
    MEM_AluResult = '0; MEM_rd = '0; MEM_regF_wr = 1'b0;
    WB_regF_wd = '0; WB_rd = '0; WB_regF_wr = 1'b0;
  endtask

  task automatic randomize_inputs();
    logic [5:0]  fl[16];
    logic [5:0]  ol[12];
    logic [15:0] i16;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    ol = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
           6'h04, 6'h05, 6'h04, 6'h05};
    rst        = ($urandom_range(0, 99) < 3);
    stop_debug = ($urandom_range(0, 99) < 15);
    inWB  = 2'($urandom);
    inMEM = 3'($urandom);
    inEXE = 4'($urandom);
    i16 = 16'($urandom);
    if (inEXE[2:1] == 2'b10) begin
      inEXE[0] = 1'b0;
      if ($urandom_range(0, 9) != 0) i16[5:0] = fl[$urandom_range(0, 15)];
    end else if (inEXE[2:1] == 2'b11) begin
      inEXE[0] = 1'b1;
    end
    inInstruction_ls = {{16{i16[15]}}, i16};
    inInmmediateOpcode = {($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 7) != 0) ? ol[$urandom_range(0, 11)] : 6'($urandom)};
    if (inMEM[2]) inInmmediateOpcode[6] = 1'b1;
    inInstructionAddress = $urandom;
    inRegA = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    inRegB = ($urandom_range(0, 3) == 0) ? inRegA : $urandom;
    in_rs   = 5'($urandom_range(0, 3));
    in_rt   = 5'($urandom_range(0, 3));
    inRT_rd = 5'($urandom);
    MEM_AluResult = $urandom; MEM_rd = 5'($urandom_range(0, 3)); MEM_regF_wr = 1'($urandom);
    WB_regF_wd    = $urandom; WB_rd  = 5'($urandom_range(0, 3)); WB_regF_wr  = 1'($urandom);
  endtask

  initial begin
    state = '0;
    clear_inputs();

    // Reset
    rst = 1'b1; inRegA = 32'hDEAD; inEXE = 4'b1100; inWB = 2'b11;
    apply();
    check("reset_result", outALUResult, 32'd0);
    check("reset_pcsel", {31'b0, outPCSel}, 32'd0);
    clear_inputs();

    // R-type ADD / SUB
    inRegA = 32'd5; inRegB = 32'd7; inEXE = 4'b1100; inInstruction_ls = 32'h20; inRT_rd = 5'd3;
    apply();
    check("add_result", outALUResult, 32'd12);
    check("add_wreg", {27'b0, outRegF_wreg}, 32'd3);
    inInstruction_ls = 32'h22;
    apply();
    check("sub_result", outALUResult, 32'hFFFF_FFFE);

    // Forwarding priority and r0 exclusion
    in_rs = 5'd2; in_rt = 5'd5; inRegA = 32'h55; inRegB = 32'd1; inInstruction_ls = 32'h20;
    MEM_rd = 5'd2; MEM_regF_wr = 1'b1; MEM_AluResult = 32'h100;
    WB_rd = 5'd2; WB_regF_wr = 1'b1; WB_regF_wd = 32'h200;
    apply();
`ifdef FORWARDING_EN
    check("fwd_mem", outALUResult, 32'h101);
`else
    check("fwd_mem", outALUResult, 32'h56);
`endif
    MEM_regF_wr = 1'b0;
    apply();
`ifdef FORWARDING_EN
    check("fwd_wb", outALUResult, 32'h201);
`else
    check("fwd_wb", outALUResult, 32'h56);
`endif
    in_rs = 5'd0; MEM_rd = 5'd0; WB_rd = 5'd0; MEM_regF_wr = 1'b1;
    apply();
    check("fwd_r0", outALUResult, 32'h56);
    clear_inputs();

    // Immediates
    inEXE = 4'b0111; inInmmediateOpcode = 7'h4D; inInstruction_ls = 32'hFFFF_8000;
    apply();
    check("ori", outALUResult, 32'h0000_8000);
    inInmmediateOpcode = 7'h4F; inInstruction_ls = 32'h1234;
    apply();
    check("lui", outALUResult, 32'h1234_0000);
    inInmmediateOpcode = 7'h4A; inInstruction_ls = 32'd1; inRegA = 32'hFFFF_FFFF;
    apply();
    check("slti", outALUResult, 32'd1);
    clear_inputs();

    // Branches
    inMEM = 3'b100; inEXE = 4'b0010; inInmmediateOpcode = 7'h44;
    inRegA = 32'd9; inRegB = 32'd9; inInstructionAddress = 32'h40; inInstruction_ls = 32'd3;
    #1;
    check("beq_taken", {31'b0, outPCSel}, 32'd1);
    check("beq_target", outPCJump, 32'h4C);
    apply();
    inRegB = 32'd8;
    #1;
    check("beq_not_taken", {31'b0, outPCSel}, 32'd0);
    apply();
    inRegB = 32'd9; stop_debug = 1'b1;
    #1;
    check("beq_stopped", {31'b0, outPCSel}, 32'd0);
    apply();

    // Stall: inputs change while frozen, then release
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      rst = 1'b0; stop_debug = 1'b1;
      apply();
      check("stall_hold", outALUResult, 32'd1);
    end
    stop_debug = 1'b0;
    apply();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      apply();
    end

    clear_inputs();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, between the ID/EX outputs of InstructionDecode and MemoryAccess.
- Selects forwarded operands and computes the ALU result and destination register.
- Resolves conditional branches combinationally (PC select and target go to fetch; PC select is also the ID flush).
- Registers the EX/MEM latch, which freezes while the debug unit asserts stop_debug.

Parameters:
- none; all widths fixed (32-bit datapath, 5-bit register indices).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- stop_debug  in  1  debug freeze; EX/MEM latch holds, branch suppressed
- inWB  in  2  [1]=RegWrite, [0]=MemToReg
- inMEM  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- inEXE  in  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
- inInstructionAddress  in  32  PC+4 of this instruction (byte address)
- inRegA, inRegB  in  32  register-file operands rs, rt
- inInstruction_ls  in  32  sign-extended imm16 (low bits carry funct[5:0], shamt[10:6])
- in_rs, in_rt, inRT_rd  in  5  rs, rt, rd indices
- inInmmediateOpcode  in  7  [6]=valid I-type, [5:0]=opcode
- MEM_AluResult, MEM_rd, MEM_regF_wr  in  32/5/1  EX/MEM forwarding source
- WB_regF_wd, WB_rd, WB_regF_wr  in  32/5/1  MEM/WB forwarding source
- outWB  out  2  registered inWB
- outMEM  out  3  registered inMEM
- outPCSel  out  1  branch taken (combinational)
- outPCJump  out  32  branch target (combinational)
- outALUResult  out  32  registered ALU result
- outALUZero  out  1  registered (result==0)
- outRegB  out  32  registered forwarded rt value (store data)
- outRegF_wreg  out  5  registered destination register

Behaviour:
- Reset: one clock; reset is synchronous and active-high (ports clk, rst). All registered outputs clear to 0 on the rising edge with rst=1; rst takes priority over stop_debug.
- Forwarding for operand A (compare in_rs):
  - MEM_regF_wr & MEM_rd!=0 & MEM_rd==in_rs selects MEM_AluResult.
  - Else WB_regF_wr & WB_rd!=0 & WB_rd==in_rs selects WB_regF_wd.
  - Else inRegA.
  - MEM source wins when both match.
- Forwarding for operand B: same rules comparing in_rt; forwarded B is fwdB.
- Operand B select: ALUSrc ? inInstruction_ls : fwdB.
- ALUOp=00 (load/store): ADD.
- ALUOp=01 (branch): SUB.
- ALUOp=10 (R-type): funct = inInstruction_ls[5:0].
  - Arithmetic/logic: ADD/ADDU 20/21, SUB/SUBU 22/23, AND 24, OR 25, XOR 26, NOR 27.
  - Compare: SLT 2A (signed), SLTU 2B (unsigned).
  - Immediate shifts: SLL 00, SRL 02, SRA 03 shift fwdB by shamt.
  - Variable shifts: SLLV 04, SRLV 06, SRAV 07 shift fwdB by A[4:0].
  - Unknown funct gives 0.
- ALUOp=11 (immediate): by opcode.
  - ADDI/ADDIU 08/09 add the sign-extended immediate.
  - SLTI 0A, SLTIU 0B compare against the sign-extended immediate.
  - ANDI 0C, ORI 0D, XORI 0E use the zero-extended imm[15:0].
  - LUI 0F gives {imm[15:0],16'h0}.
  - Any other opcode, or inInmmediateOpcode[6]=0, gives 0.
- Arithmetic wraps modulo 2^32; no overflow exceptions.
- Destination: outRegF_wreg = RegDst ? inRT_rd : in_rt.
- Branch:
  - outPCJump = inInstructionAddress + (inInstruction_ls<<2), mod 2^32.
  - BEQ (opcode 04) is taken when A==fwdB; BNE (05) when A!=fwdB.
  - outPCSel = Branch & taken & ~stop_debug & ~rst.
- Latch: each rising edge with stop_debug=0 and rst=0 loads outWB, outMEM, result, zero, fwdB and dest. With stop_debug=1, all registered outputs hold.

Optional Feature:
- FORWARDING_EN: when defined, forwarding mux active as above.
- When undefined: A=inRegA, fwdB=inRegB; MEM_* and WB_* inputs ignored; the hazard-free software contract applies.

Decomposition:
- Shared package: ALUOp encodings, funct codes, opcode codes, bit positions of WB/MEM/EX fields.
- Natural sub-module: alu (operands A, B, shamt, 4-bit op → 32-bit result, zero).

Test Plan:
- Reset: rst=1 for one edge → all registered outputs 0, outPCSel=0.
- R-type ADD: A=5, B=7, EXE=4'b1100, funct 20, rd=3 → next edge outALUResult=12, outRegF_wreg=3; SUB 5-7 → 0xFFFFFFFE.
- Forwarding: in_rs=2, MEM_rd=2, MEM_regF_wr=1, MEM_AluResult=0x100, WB_rd=2 WB_regF_wd=0x200, ADD with B=1 → 0x101; clear MEM_regF_wr → 0x201; rd 0 never forwarded.
- Immediate: ORI opcode 0D, imm=0xFFFF8000, A=0 → 0x00008000; LUI imm 0x1234 → 0x12340000; SLTI A=-1, imm=1 → 1.
- Branch: BEQ A=B=9, PC+4=0x40, imm=3 → outPCSel=1, outPCJump=0x4C same cycle; A≠B → 0; stop_debug=1 → 0.
- Stall: stop_debug=1 while inputs change → outputs hold previous values; release → loads current inputs next edge.
